// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN/ILEN  : address and instruction widths
//   INSTR_NOP  : canonical NOP (addi x0,x0,0), shown to decode when nothing is held
//   PC_INC     : sequential PC increment
//   fetch_state_t : fetch FSM states
//   pc_sel_t      : next-PC source selected by the fetch FSM
package riscv_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam int unsigned     ILEN      = 32;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned     PC_INC    = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_KEEP,
    PC_SEQ,
    PC_REDIR,
    PC_TARGET
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter generator for the fetch stage.
// Holds the PC, the +4 sequential adder, and the kill flag with its latched
// redirect target (used when a redirect arrives while a request is in flight).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pc_sel      : next-PC source (keep / +4 / redirect now / latched target)
//   redir_tgt   : redirect target, already masked by the caller
//   kill_set    : latch redir_tgt and mark the in-flight response as stale
//   kill_clr    : clear the stale marker
//   pc          : current PC
//   kill        : in-flight response must be discarded
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_t         pc_sel,
  input  logic [XLEN-1:0] redir_tgt,
  input  logic            kill_set,
  input  logic            kill_clr,
  output logic [XLEN-1:0] pc,
  output logic            kill
);

  logic [XLEN-1:0] kill_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEQ:    pc <= pc + XLEN'(PC_INC);
        PC_REDIR:  pc <= redir_tgt;
        PC_TARGET: pc <= kill_tgt;
        default:   pc <= pc;
      endcase
    end
  end

  // A later redirect while kill is pending overwrites the target: last one wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill     <= 1'b0;
      kill_tgt <= '0;
    end else if (kill_set) begin
      kill     <= 1'b1;
      kill_tgt <= redir_tgt;
    end else if (kill_clr) begin
      kill     <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and presents each fetched instruction to decode over a
// valid/ready handshake. Redirects from branch/jump logic override PC+4.
// Optional build macro FETCH_MISALIGN_EN: adds if_misalign and reports
// misaligned redirect targets instead of fetching them; when undefined the
// low two redirect address bits are forced to zero.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt     : memory request channel
//   imem_rvalid/imem_rdata          : memory response channel
//   redirect_valid/redirect_pc      : taken branch/jump target
//   if_valid/if_ready/if_pc/if_instr: handshake to decode
//   if_misalign (FETCH_MISALIGN_EN) : held PC is a misaligned redirect target
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            if_misalign
`endif
);

  fetch_state_t    state, state_n;
  pc_sel_t         pc_sel;
  logic            kill_set, kill_clr, kill;
  logic            capture, release_hold, set_mis;
  logic            redir_ok, redir_mis, mis_hold;
  logic [XLEN-1:0] pc, redir_tgt;

`ifdef FETCH_MISALIGN_EN
  assign redir_tgt = redirect_pc;
  assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign mis_hold  = if_misalign;
`else
  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign redir_mis = 1'b0;
  assign mis_hold  = 1'b0;
`endif

  assign redir_ok = redirect_valid && !redir_mis;

  fetch_pc_gen #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_sel    (pc_sel),
    .redir_tgt (redir_tgt),
    .kill_set  (kill_set),
    .kill_clr  (kill_clr),
    .pc        (pc),
    .kill      (kill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    pc_sel       = PC_KEEP;
    kill_set     = 1'b0;
    kill_clr     = 1'b0;
    capture      = 1'b0;
    release_hold = 1'b0;
    set_mis      = 1'b0;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redir_ok) pc_sel = PC_REDIR;
      end
      // Address must stay stable until granted, so a redirect here only
      // marks the eventual response as stale.
      REQ: begin
        if (redir_ok) kill_set = 1'b1;
        if (imem_gnt) state_n = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_n = REQ;
          if (redir_ok) begin
            pc_sel   = PC_REDIR;
            kill_clr = 1'b1;
          end else if (kill) begin
            pc_sel   = PC_TARGET;
            kill_clr = 1'b1;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (redir_ok) begin
          kill_set = 1'b1;
        end
      end
      HOLD: begin
        if (redir_ok) begin
          pc_sel       = PC_REDIR;
          release_hold = 1'b1;
          state_n      = REQ;
        end else if (if_ready && !mis_hold) begin
          pc_sel       = PC_SEQ;
          release_hold = 1'b1;
          state_n      = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
    // A misaligned target is reported from HOLD without fetching; any
    // in-flight response is then ignored because HOLD does not consume rvalid.
    if (redir_mis) begin
      state_n      = HOLD;
      pc_sel       = PC_KEEP;
      kill_set     = 1'b0;
      kill_clr     = 1'b1;
      capture      = 1'b0;
      release_hold = 1'b0;
      set_mis      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= INSTR_NOP;
    end else if (set_mis) begin
      if_valid <= 1'b1;
      if_pc    <= redirect_pc;
      if_instr <= INSTR_NOP;
    end else if (capture) begin
      if_valid <= 1'b1;
      if_pc    <= pc;
      if_instr <= imem_rdata;
    end else if (release_hold) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            if_misalign <= 1'b0;
    else if (set_mis)      if_misalign <= 1'b1;
    else if (release_hold) if_misalign <= 1'b0;
  end
`endif

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of per-cycle expectations for
// the basic stream and backpressure, then hand-written redirect, grant-stall,
// async-reset, wrap and low-address-bit sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        auto_mem;
  logic        seen_bad;
  logic [31:0] forbid_pc;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  function automatic vec_t mk(input logic r, input logic q, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input logic [31:0] i);
    vec_t t;
    t.ready = r; t.exp_req = q; t.exp_addr = a;
    t.exp_valid = v; t.exp_pc = p; t.exp_instr = i;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample the request handshake before the edge, then model a
  // memory that answers exactly one cycle after each accepted request.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req && imem_gnt;
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = acc;
      imem_rdata  = acc ? mem_word(a) : 32'h0;
    end
    if (if_valid && (if_instr == 32'hDEAD_BEEF || if_pc == forbid_pc)) seen_bad = 1'b1;
  endtask

  task automatic run_to_valid(input string name, input logic [31:0] exp_pc);
    int unsigned n;
    n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, n, 32'd2);
    chk({name, "_pc"}, if_pc, exp_pc);
    chk({name, "_instr"}, if_instr, mem_word(exp_pc));
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 32'h0, 0, 32'h0, NOP);
    tbl[1]  = mk(1, 1, 32'h0, 0, 32'h0, NOP);
    tbl[2]  = mk(1, 0, 32'h0, 0, 32'h0, NOP);
    tbl[3]  = mk(1, 0, 32'h0, 1, 32'h0, mem_word(32'h0));
    tbl[4]  = mk(1, 1, 32'h4, 0, 32'h0, mem_word(32'h0));
    tbl[5]  = mk(1, 0, 32'h4, 0, 32'h0, mem_word(32'h0));
    tbl[6]  = mk(1, 0, 32'h4, 1, 32'h4, mem_word(32'h4));
    tbl[7]  = mk(1, 1, 32'h8, 0, 32'h4, mem_word(32'h4));
    tbl[8]  = mk(1, 0, 32'h8, 0, 32'h4, mem_word(32'h4));
    for (int i = 9; i < 14; i++) tbl[i] = mk(0, 0, 32'h8, 1, 32'h8, mem_word(32'h8));
    tbl[14] = mk(1, 0, 32'h8, 1, 32'h8, mem_word(32'h8));

    rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    auto_mem = 1'b1; seen_bad = 1'b0; forbid_pc = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic stream then 5 cycles of backpressure in HOLD.
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t%0d_req", i),   imem_req,  tbl[i].exp_req);
      chk($sformatf("t%0d_addr", i),  imem_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_valid", i), if_valid,  tbl[i].exp_valid);
      chk($sformatf("t%0d_pc", i),    if_pc,     tbl[i].exp_pc);
      chk($sformatf("t%0d_instr", i), if_instr,  tbl[i].exp_instr);
      if_ready = tbl[i].ready;
      tick();
    end

    // Redirect while waiting for the response; the response must be dropped.
    chk("bp_next_req", imem_req, 1'b1);
    chk("bp_next_addr", imem_addr, 32'hC);
    auto_mem = 1'b0;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("wr_req", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("wr_req2", imem_req, 1'b1);
    chk("wr_addr", imem_addr, 32'h100);
    chk("wr_valid", if_valid, 1'b0);
    auto_mem = 1'b1; imem_gnt = 1'b1;
    run_to_valid("wr", 32'h100);

    // Redirect in HOLD with if_ready high the same cycle.
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("hr_valid", if_valid, 1'b0);
    chk("hr_req", imem_req, 1'b1);
    chk("hr_addr", imem_addr, 32'h200);
    run_to_valid("hr", 32'h200);

    // Grant held low 4 cycles, redirect in the second; address must not move.
    imem_gnt = 1'b0;
    tick();
    forbid_pc = 32'h204;
    for (int i = 0; i < 4; i++) begin
      redirect_valid = (i == 1);
      redirect_pc    = 32'h300;
      chk($sformatf("gs%0d_req", i), imem_req, 1'b1);
      chk($sformatf("gs%0d_addr", i), imem_addr, 32'h204);
      tick();
    end
    redirect_valid = 1'b0;
    chk("gs_addr_at_gnt", imem_addr, 32'h204);
    imem_gnt = 1'b1;
    tick();
    tick();
    chk("gs_refetch_req", imem_req, 1'b1);
    chk("gs_refetch_addr", imem_addr, 32'h300);
    run_to_valid("gs", 32'h300);

    // Asynchronous reset mid-WAIT, then a stray response after release.
    tick();
    auto_mem = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", if_valid, 1'b0);
    chk("ar_pc", if_pc, 32'h0);
    chk("ar_instr", if_instr, NOP);
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ar_restart_req", imem_req, 1'b1);
    chk("ar_restart_addr", imem_addr, 32'h0);
    tick();
    chk("ar_stray_valid", if_valid, 1'b0);
    imem_rvalid = 1'b0; auto_mem = 1'b1; imem_gnt = 1'b1;
    run_to_valid("ar", 32'h0);

    // PC wraps from the top word to zero.
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wp_addr", imem_addr, 32'hFFFF_FFFC);
    run_to_valid("wp", 32'hFFFF_FFFC);
    if_ready = 1'b1;
    tick();
    chk("wp_wrap_addr", imem_addr, 32'h0);
    if_ready = 1'b0;
    run_to_valid("wp2", 32'h0);

`ifdef FETCH_MISALIGN_EN
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    chk("ma_valid", if_valid, 1'b1);
    chk("ma_flag", if_misalign, 1'b1);
    chk("ma_pc", if_pc, 32'h102);
    chk("ma_instr", if_instr, NOP);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ma%0d_req", i), imem_req, 1'b0);
      tick();
    end
    chk("ma_still_valid", if_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("ma_exit_req", imem_req, 1'b1);
    chk("ma_exit_addr", imem_addr, 32'h400);
    chk("ma_exit_flag", if_misalign, 1'b0);
`else
    redirect_valid = 1'b1; redirect_pc = 32'h106;
    tick();
    redirect_valid = 1'b0;
    chk("mk_req", imem_req, 1'b1);
    chk("mk_addr", imem_addr, 32'h104);
`endif

    chk("no_stale_resp", seen_bad, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
